// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: latches the user's throw, picks the computer's
// throw (LFSR or forced), sequences the image drawer, judges the round and keeps scores.
module rps_round_ctrl #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         SCORE_W   = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               go_n,
  input  logic [1:0]         user_choice,
  input  logic               force_en,
  input  logic [1:0]         force_choice,
  input  logic               draw_done,
  output logic               draw_start,
  output logic               player,
  output logic [1:0]         choice,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic               busy,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] comp_score
);

  typedef enum logic [2:0] {IDLE, PICK, DRAW_U, WAIT_U, DRAW_C, WAIT_C, JUDGE} state_t;

  state_t             state_q;
  logic               go_s1_q, go_s2_q, go_s3_q;
  logic               go_pulse;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [1:0]         u_ch_q, c_ch_q;
  logic [1:0]         judge_res;
  logic               draw_start_q, player_q, result_valid_q, busy_q;
  logic [1:0]         choice_q, result_q;
  logic [SCORE_W-1:0] user_score_q, comp_score_q;

  // 11 is not a legal throw; it is folded onto paper.
  function automatic logic [1:0] map_throw(input logic [1:0] t);
    return (t == 2'b11) ? 2'b10 : t;
  endfunction

  // Rock(00) beats scissor(01), scissor beats paper(10), paper beats rock.
  function automatic logic [1:0] judge(input logic [1:0] u, input logic [1:0] c);
    if (u == c)
      return 2'b00;
    else if ((u == 2'b00 && c == 2'b01) || (u == 2'b01 && c == 2'b10) ||
             (u == 2'b10 && c == 2'b00))
      return 2'b01;
    else
      return 2'b10;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  assign go_pulse  = go_s3_q & ~go_s2_q;
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign judge_res = judge(u_ch_q, c_ch_q);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      go_s1_q <= 1'b1;
      go_s2_q <= 1'b1;
      go_s3_q <= 1'b1;
      lfsr_q  <= LFSR_SEED;
    end else begin
      go_s1_q <= go_n;
      go_s2_q <= go_s1_q;
      go_s3_q <= go_s2_q;
      lfsr_q  <= lfsr_d;
    end
  end

  // Outputs are registered and updated on the transition into the state that owns them.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      u_ch_q         <= 2'b00;
      c_ch_q         <= 2'b00;
      draw_start_q   <= 1'b0;
      player_q       <= 1'b0;
      choice_q       <= 2'b00;
      result_q       <= 2'b00;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      user_score_q   <= '0;
      comp_score_q   <= '0;
    end else begin
      draw_start_q <= 1'b0;
      case (state_q)
        IDLE: if (go_pulse) begin
          u_ch_q         <= map_throw(user_choice);
          result_valid_q <= 1'b0;
          busy_q         <= 1'b1;
          state_q        <= PICK;
        end
        PICK: if (force_en || lfsr_q[1:0] != 2'b11) begin
          c_ch_q       <= force_en ? map_throw(force_choice) : lfsr_q[1:0];
          draw_start_q <= 1'b1;
          player_q     <= 1'b0;
          choice_q     <= u_ch_q;
          state_q      <= DRAW_U;
        end
        DRAW_U: state_q <= WAIT_U;
        WAIT_U: if (draw_done) begin
          draw_start_q <= 1'b1;
          player_q     <= 1'b1;
          choice_q     <= c_ch_q;
          state_q      <= DRAW_C;
        end
        DRAW_C: state_q <= WAIT_C;
        WAIT_C: if (draw_done) state_q <= JUDGE;
        JUDGE: begin
          result_q       <= judge_res;
          if (judge_res == 2'b01) user_score_q <= sat_inc(user_score_q);
          if (judge_res == 2'b10) comp_score_q <= sat_inc(comp_score_q);
          result_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign draw_start   = draw_start_q;
  assign player       = player_q;
  assign choice       = choice_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign user_score   = user_score_q;
  assign comp_score   = comp_score_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: scenario tasks against a game-rule reference model.
module tb_rps_round_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n, go_n, force_en, draw_done;
  logic [1:0] user_choice, force_choice;
  logic       draw_start, player, result_valid, busy;
  logic [1:0] choice, result;
  logic [3:0] user_score, comp_score;

  int n_vec = 0;
  int n_err = 0;
  int mu = 0, mc = 0;
  logic [2:0] ds_q[$];

  rps_round_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .go_n(go_n), .user_choice(user_choice),
    .force_en(force_en), .force_choice(force_choice), .draw_done(draw_done),
    .draw_start(draw_start), .player(player), .choice(choice), .result(result),
    .result_valid(result_valid), .busy(busy), .user_score(user_score), .comp_score(comp_score)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (draw_start) ds_q.push_back({player, choice});

  function automatic int mapt(input logic [1:0] t);
    return (t == 2'b11) ? 2 : int'(t);
  endfunction

  function automatic logic [1:0] ref_result(input int u, input int c);
    if (u == c) return 2'b00;
    if ((u == 0 && c == 1) || (u == 1 && c == 2) || (u == 2 && c == 0)) return 2'b01;
    return 2'b10;
  endfunction

  function automatic void model_score(input logic [1:0] r);
    if (r == 2'b01 && mu < 15) mu++;
    if (r == 2'b10 && mc < 15) mc++;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(negedge CLOCK_50); #1; end
  endtask

  // Press the key and run until the round completes (bounded).
  task automatic play(output bit ok, output bit rv_cleared);
    bit seen = 0;
    ok = 0; rv_cleared = 1;
    ds_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      go_n = (cyc < 4) ? 1'b0 : 1'b1;
      tick(1);
      if (busy && !seen) begin seen = 1; rv_cleared = !result_valid; end
      if (seen && !busy) begin ok = 1; break; end
    end
    go_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; go_n = 1'b1; draw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      go_n = 1'($urandom); draw_done = 1'($urandom);
      tick(1);
      n_vec++;
      if (draw_start !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL reset_hold: draw_start=%b busy=%b required 0 0", draw_start, busy);
      end
    end
    go_n = 1'b1; draw_done = 1'b0;
    tick(1);
    n_vec++;
    if ({player, choice, result, result_valid, user_score, comp_score} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_vals: player=%b choice=%b result=%b rv=%b us=%0d cs=%0d required all 0",
               player, choice, result, result_valid, user_score, comp_score);
    end
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_forced(input logic [1:0] u, input logic [1:0] fc);
    bit ok, rvc;
    logic [1:0] r;
    user_choice = u; force_en = 1'b1; force_choice = fc; draw_done = 1'b1;
    play(ok, rvc);
    r = ref_result(mapt(u), mapt(fc));
    model_score(r);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL forced_timeout: round did not finish, required finish"); end
    n_vec++;
    if (!rvc) begin n_err++; $display("FAIL rv_clear: result_valid=1 at round start, required 0"); end
    n_vec++;
    if (ds_q.size() != 2) begin
      n_err++; $display("FAIL forced_pulses: got %0d draw_start pulses, required 2", ds_q.size());
    end else begin
      n_vec++;
      if (ds_q[0] !== {1'b0, 2'(mapt(u))} || ds_q[1] !== {1'b1, 2'(mapt(fc))}) begin
        n_err++;
        $display("FAIL forced_draws: got %b,%b required %b,%b", ds_q[0], ds_q[1],
                 {1'b0, 2'(mapt(u))}, {1'b1, 2'(mapt(fc))});
      end
    end
    n_vec++;
    if (result !== r || result_valid !== 1'b1 || user_score !== 4'(mu) || comp_score !== 4'(mc)) begin
      n_err++;
      $display("FAIL forced_judge: result=%b rv=%b us=%0d cs=%0d required %b 1 %0d %0d",
               result, result_valid, user_score, comp_score, r, mu, mc);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 16; i++) test_forced(2'b00, 2'b10);
    n_vec++;
    if (comp_score !== 4'd15 || user_score !== 4'(mu) || result !== 2'b10) begin
      n_err++;
      $display("FAIL saturation: cs=%0d us=%0d result=%b required 15 %0d 10", comp_score, user_score,
               result, mu);
    end
  endtask

  task automatic test_busy_drop;
    bit ok = 0;
    user_choice = 2'b01; force_en = 1'b1; force_choice = 2'b10; draw_done = 1'b0;
    ds_q.delete();
    go_n = 1'b0; tick(4); go_n = 1'b1;
    for (int i = 0; i < 50 && ds_q.size() < 1; i++) tick(1);
    go_n = 1'b0; tick(4); go_n = 1'b1; tick(6);
    n_vec++;
    if (busy !== 1'b1 || ds_q.size() != 1) begin
      n_err++; $display("FAIL drop_wait: busy=%b pulses=%0d required 1 1", busy, ds_q.size());
    end
    draw_done = 1'b1;
    for (int i = 0; i < 50; i++) begin tick(1); if (!busy) begin ok = 1; break; end end
    model_score(2'b01);
    n_vec++;
    if (!ok || ds_q.size() != 2 || result !== 2'b01 || user_score !== 4'(mu)) begin
      n_err++;
      $display("FAIL drop_round: done=%0d pulses=%0d result=%b us=%0d required 1 2 01 %0d",
               ok, ds_q.size(), result, user_score, mu);
    end
    tick(12);
    n_vec++;
    if (busy !== 1'b0 || ds_q.size() != 2) begin
      n_err++; $display("FAIL drop_replay: busy=%b pulses=%0d required 0 2", busy, ds_q.size());
    end
  endtask

  task automatic test_reset_mid;
    user_choice = 2'b00; force_en = 1'b1; force_choice = 2'b01; draw_done = 1'b0;
    ds_q.delete();
    go_n = 1'b0; tick(4); go_n = 1'b1;
    for (int i = 0; i < 50 && ds_q.size() < 1; i++) tick(1);
    tick(1); draw_done = 1'b1; tick(1); draw_done = 1'b0;
    for (int i = 0; i < 50 && ds_q.size() < 2; i++) tick(1);
    tick(3);
    n_vec++;
    if (busy !== 1'b1 || ds_q.size() != 2) begin
      n_err++; $display("FAIL mid_wait_c: busy=%b pulses=%0d required 1 2", busy, ds_q.size());
    end
    reset_n = 1'b0;
    #1;
    mu = 0; mc = 0;
    n_vec++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || user_score !== 4'd0 || comp_score !== 4'd0 ||
        draw_start !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b rv=%b us=%0d cs=%0d ds=%b required 0 0 0 0 0",
               busy, result_valid, user_score, comp_score, draw_start);
    end
    tick(2); reset_n = 1'b1; tick(3);
  endtask

  task automatic test_lfsr_rounds;
    bit ok, rvc;
    bit seen[3] = '{0, 0, 0};
    int c;
    logic [1:0] u, r;
    force_en = 1'b0; draw_done = 1'b1;
    for (int k = 0; k < 300; k++) begin
      u = 2'($urandom_range(0, 3));
      user_choice = u; force_choice = 2'($urandom);
      play(ok, rvc);
      n_vec++;
      if (!ok || ds_q.size() != 2) begin
        n_err++; $display("FAIL lfsr_round %0d: done=%0d pulses=%0d required 1 2", k, ok, ds_q.size());
        continue;
      end
      c = int'(ds_q[1][1:0]);
      n_vec++;
      if (ds_q[1][2] !== 1'b1 || c == 3 || ds_q[0] !== {1'b0, 2'(mapt(u))}) begin
        n_err++; $display("FAIL lfsr_choice %0d: got %b,%b required user %0d and comp not 11",
                          k, ds_q[0], ds_q[1], mapt(u));
        continue;
      end
      seen[c] = 1;
      r = ref_result(mapt(u), c);
      model_score(r);
      n_vec++;
      if (result !== r || user_score !== 4'(mu) || comp_score !== 4'(mc)) begin
        n_err++; $display("FAIL lfsr_judge %0d: result=%b us=%0d cs=%0d required %b %0d %0d",
                          k, result, user_score, comp_score, r, mu, mc);
      end
    end
    n_vec++;
    if (!(seen[0] && seen[1] && seen[2])) begin
      n_err++; $display("FAIL lfsr_cover: seen rock=%0d scissor=%0d paper=%0d required all 1",
                        seen[0], seen[1], seen[2]);
    end
  endtask

  initial begin
    reset_n = 1'b0; go_n = 1'b1; draw_done = 1'b0;
    user_choice = 2'b00; force_en = 1'b0; force_choice = 2'b00;
    test_reset();
    test_forced(2'b00, 2'b01);
    test_forced(2'b11, 2'b00);
    test_forced(2'b10, 2'b10);
    test_saturation();
    test_busy_drop();
    test_reset_mid();
    test_forced(2'b01, 2'b11);
    test_lfsr_rounds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
